// File: rtl/restore_origin_pkg.sv
// Shared types and constants for the origin-restore block: coordinate
// width, vertex count, coordinate/vertex types and the emitter FSM states.
package restore_origin_pkg;

  localparam int COORD_W   = 16;
  localparam int VTX_COUNT = 4;

  // Index of the final vertex of a primitive
  localparam logic [1:0] LAST_IDX = 2'(VTX_COUNT - 1);

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t X;
    coord_t Y;
    coord_t Z;
  } vertex_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/restore_origin_sat_add16.sv
// Signed saturating adder: widens both operands by one bit, adds, and
// clamps the result back into the coordinate range, flagging any clamp.
module sat_add16
  import restore_origin_pkg::*;
(
  input  logic signed [COORD_W-1:0] a,
  input  logic signed [COORD_W-1:0] b,
  output logic signed [COORD_W-1:0] sum,
  output logic                      sat
);

  localparam coord_t C_MAX = {1'b0, {(COORD_W-1){1'b1}}};
  localparam coord_t C_MIN = {1'b1, {(COORD_W-1){1'b0}}};

  logic signed [COORD_W:0] sum_w;

  // Clamp a one-bit-wider sum into the coordinate range
  function automatic coord_t sat_clip(input logic signed [COORD_W:0] w);
    if (w > C_MAX)
      return C_MAX;
    else if (w < C_MIN)
      return C_MIN;
    else
      return w[COORD_W-1:0];
  endfunction

  // Overflow happened when the two top bits of the wide sum disagree
  function automatic logic sat_flag(input logic signed [COORD_W:0] w);
    return w[COORD_W] ^ w[COORD_W-1];
  endfunction

  assign sum_w = $signed({a[COORD_W-1], a}) + $signed({b[COORD_W-1], b});
  assign sum   = sat_clip(sum_w);
  assign sat   = sat_flag(sum_w);

endmodule

// File: rtl/restore_origin.sv
// Captures a shifted primitive (four origin-relative vertices plus the
// origin) in one cycle, then emits the four restored absolute vertices one
// per handshake. The captured copy isolates emission from input changes.
module restore_origin
  import restore_origin_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] vtx1_X,
  input  logic signed [COORD_W-1:0] vtx1_Y,
  input  logic signed [COORD_W-1:0] vtx1_Z,
  input  logic signed [COORD_W-1:0] vtx2_X,
  input  logic signed [COORD_W-1:0] vtx2_Y,
  input  logic signed [COORD_W-1:0] vtx2_Z,
  input  logic signed [COORD_W-1:0] vtx3_X,
  input  logic signed [COORD_W-1:0] vtx3_Y,
  input  logic signed [COORD_W-1:0] vtx3_Z,
  input  logic signed [COORD_W-1:0] vtx4_X,
  input  logic signed [COORD_W-1:0] vtx4_Y,
  input  logic signed [COORD_W-1:0] vtx4_Z,
  input  logic signed [COORD_W-1:0] org_X,
  input  logic signed [COORD_W-1:0] org_Y,
  input  logic signed [COORD_W-1:0] org_Z,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COORD_W-1:0] out_X,
  output logic signed [COORD_W-1:0] out_Y,
  output logic signed [COORD_W-1:0] out_Z,
  output logic [1:0]                out_idx,
  output logic                      out_last,
  output logic                      out_sat
);

  state_t     state;
  logic       in_ready_q;
  logic       out_valid_q;
  logic [1:0] idx_q;

  vertex_t vtx_in [VTX_COUNT];
  vertex_t vtx_p0 [VTX_COUNT];
  vertex_t org_p0;
  vertex_t cur;

  coord_t sum_x, sum_y, sum_z;
  logic   sat_x, sat_y, sat_z;

  assign vtx_in[0] = {vtx1_X, vtx1_Y, vtx1_Z};
  assign vtx_in[1] = {vtx2_X, vtx2_Y, vtx2_Z};
  assign vtx_in[2] = {vtx3_X, vtx3_Y, vtx3_Z};
  assign vtx_in[3] = {vtx4_X, vtx4_Y, vtx4_Z};

  // Capture/emit FSM; handshake flags are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      org_p0      <= '0;
      for (int i = 0; i < VTX_COUNT; i++)
        vtx_p0[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < VTX_COUNT; i++)
              vtx_p0[i] <= vtx_in[i];
            org_p0      <= {org_X, org_Y, org_Z};
            idx_q       <= '0;
            state       <= EMIT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              state       <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          idx_q       <= '0;
        end
      endcase
    end
  end

  // Restore stage: current vertex plus origin, one adder per axis
  assign cur = vtx_p0[idx_q];

  sat_add16 u_add_x (.a(cur.X), .b(org_p0.X), .sum(sum_x), .sat(sat_x));
  sat_add16 u_add_y (.a(cur.Y), .b(org_p0.Y), .sum(sum_y), .sat(sat_y));
  sat_add16 u_add_z (.a(cur.Z), .b(org_p0.Z), .sum(sum_z), .sat(sat_z));

  // Outputs read as zero whenever no vertex is being presented
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_X     = out_valid_q ? sum_x : '0;
  assign out_Y     = out_valid_q ? sum_y : '0;
  assign out_Z     = out_valid_q ? sum_z : '0;
  assign out_idx   = out_valid_q ? idx_q : 2'd0;
  assign out_last  = out_valid_q && (idx_q == LAST_IDX);
  assign out_sat   = out_valid_q && (sat_x || sat_y || sat_z);

endmodule

// File: doc/restore_origin.md
RESTORE_ORIGIN -- requirements
Module: restore_origin

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be rst_n, asynchronous, active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream shifted primitive valid.
REQ-005 in_ready  output  1  block can capture a primitive.
REQ-006 vtxN_X, vtxN_Y, vtxN_Z (N=1..4)  input  16 signed each  origin-relative vertex coordinates.
REQ-007 org_X, org_Y, org_Z  input  16 signed each  origin offset to add back.
REQ-008 out_valid  output  1  out_X/Y/Z hold a valid restored vertex.
REQ-009 out_ready  input  1  downstream accepts the current vertex.
REQ-010 out_X, out_Y, out_Z  output  16 signed each  restored absolute coordinates.
REQ-011 out_idx  output  2  vertex index, 0..3 for vtx1..vtx4.
REQ-012 out_last  output  1  high with out_idx=3.
REQ-013 out_sat  output  1  at least one axis of the current vertex saturated.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and EMIT.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid 0; in EMIT, in_ready SHALL be 0 and out_valid 1.
REQ-016 In IDLE, in_valid=1 SHALL capture all 12 vertex coordinates and org_X/Y/Z on the same edge, set out_idx=0, and enter EMIT.
REQ-017 The first vertex SHALL be valid the cycle after capture; latency is 1 cycle.
REQ-018 Each output axis SHALL be the 17-bit signed sum of the captured vertex axis and the captured origin axis, saturated to [-32768, 32767].
REQ-019 out_sat SHALL be the OR of the three per-axis saturation conditions for the current out_idx.
REQ-020 While out_valid=1 and out_ready=0, out_X/Y/Z, out_idx, out_last and out_sat SHALL hold stable.
REQ-021 On out_valid and out_ready with out_idx<3, out_idx SHALL increment next cycle.
REQ-022 On out_valid and out_ready with out_idx=3, the FSM SHALL return to IDLE, and in_ready SHALL be 1 the following cycle; there is no same-cycle re-capture.
REQ-023 Changes to the vtx or org inputs after capture SHALL NOT affect the vertices being emitted.
REQ-024 Throughput SHALL be one vertex per cycle under continuous out_ready=1, which gives 5 cycles per primitive including the capture cycle.
REQ-025 When out_valid=0, out_X/Y/Z, out_idx, out_last and out_sat SHALL be 0.

Reset
REQ-026 Asserting rst_n=0 at any time, including mid-EMIT, SHALL immediately force IDLE and clear out_valid, out_idx, out_last, out_sat, out_X/Y/Z and all captured registers to 0.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge, and any partially emitted primitive SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold COORD_W=16, VTX_COUNT=4, the signed coordinate typedef, the vertex struct {X,Y,Z}, and the FSM state enum.
REQ-029 Saturating addition SHALL be one sub-module, sat_add16 (two 16-bit signed in; 16-bit result and sat flag out), instantiated three times, with the vertex selected by a mux on out_idx.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- vtx1=(1,2,3), vtx2=(-4,5,0), vtx3=(0,0,0), vtx4=(100,-100,7); org=(10,20,30); out_ready=1 -> out (11,22,33), (6,25,30), (10,20,30), (110,-80,37) on 4 consecutive cycles; out_last only on the 4th; out_sat=0 throughout.
- vtx1=(32000,-32000,0), org=(1000,-1000,0) -> out (32767,-32768,0) with out_sat=1.
- out_ready held 0 for 3 cycles at out_idx=1, while the vtx/org inputs are changed -> out_idx and outputs stay frozen and unchanged, then resume at idx=1.
- in_valid held 1 continuously -> in_ready low during EMIT, next capture exactly one cycle after the idx=3 handshake, 5 cycles per primitive.
- rst_n pulsed low at out_idx=2 -> all outputs 0 asynchronously; in_ready=1 after release; no further vertices of that primitive appear.
